// File: rtl/player_ctrl.sv
// Player sprite controller: keyboard movement with arena/pillar collision,
// bomb drop with cooldown, blast hit detection and a life/respawn state machine.
module player_ctrl #(
    parameter int unsigned NUM_BOMBS     = 4,
    parameter int unsigned STEP          = 1,
    parameter int unsigned SIZE_X        = 19,
    parameter int unsigned SIZE_Y        = 26,
    parameter int unsigned X_MIN         = 32,
    parameter int unsigned X_MAX         = 575,
    parameter int unsigned Y_MIN         = 32,
    parameter int unsigned Y_MAX         = 447,
    parameter int unsigned SPAWN_X       = 32,
    parameter int unsigned SPAWN_Y       = 32,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned DEATH_FRAMES  = 30,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned BOMB_COOLDOWN = 60,
    parameter logic [7:0]  KEY_UP        = 8'h52,
    parameter logic [7:0]  KEY_DOWN      = 8'h51,
    parameter logic [7:0]  KEY_LEFT      = 8'h50,
    parameter logic [7:0]  KEY_RIGHT     = 8'h4F,
    parameter logic [7:0]  KEY_BOMB      = 8'h13
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic [7:0]              keycode,
    input  logic [10*NUM_BOMBS-1:0] blast_x,
    input  logic [10*NUM_BOMBS-1:0] blast_y,
    input  logic [10*NUM_BOMBS-1:0] blast_xs,
    input  logic [10*NUM_BOMBS-1:0] blast_ys,
    input  logic [NUM_BOMBS-1:0]    blast_active,
    output logic [9:0]              userX,
    output logic [9:0]              userY,
    output logic                    bomb_drop,
    output logic                    collide,
    output logic [3:0]              lives,
    output logic [1:0]              state,
    output logic                    invuln
);

    typedef enum logic [1:0] {
        S_ALIVE   = 2'd0,
        S_HIT     = 2'd1,
        S_RESPAWN = 2'd2,
        S_DEAD    = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic [9:0]  r_x, r_y, w_x_next, w_y_next;
    logic [3:0]  r_lives, w_lives_next;
    logic [15:0] r_invuln, w_invuln_next;
    logic [15:0] r_cool, w_cool_next;
    logic [15:0] r_hitcnt, w_hitcnt_next;
    logic [7:0]  r_prev_key;
    logic        r_bomb, w_bomb_next;
    logic        r_collide, w_collide_next;

    logic        w_overlap, w_hit, w_move, w_legal, w_bomb_edge;
    logic [11:0] w_cx, w_cy;

    // Strict box overlap between the player sprite and one blast region.
    function automatic logic f_overlap(input logic [9:0] ux, uy, bx, by, bxs, bys);
        return ({1'b0, ux} < ({1'b0, bx} + {1'b0, bxs})) &&
               ({1'b0, bx} < ({1'b0, ux} + 11'(SIZE_X))) &&
               ({1'b0, uy} < ({1'b0, by} + {1'b0, bys})) &&
               ({1'b0, by} < ({1'b0, uy} + 11'(SIZE_Y)));
    endfunction

    // Pillars tile the arena: the upper half of each 64-pixel period, offset by 32.
    function automatic logic f_pillar(input logic [10:0] px, py);
        logic [10:0] dx, dy;
        dx = px - 11'd32;
        dy = py - 11'd32;
        return (px >= 11'd32) && (py >= 11'd32) && dx[5] && dy[5];
    endfunction

    function automatic logic f_legal(input logic [11:0] cx, cy);
        logic [11:0] rx, by;
        rx = cx + 12'(SIZE_X);
        by = cy + 12'(SIZE_Y);
        return !cx[11] && !cy[11] &&
               (cx >= 12'(X_MIN)) && (rx <= 12'(X_MAX)) &&
               (cy >= 12'(Y_MIN)) && (by <= 12'(Y_MAX)) &&
               !f_pillar(cx[10:0], cy[10:0]) &&
               !f_pillar(rx[10:0] - 11'd1, cy[10:0]) &&
               !f_pillar(cx[10:0], by[10:0] - 11'd1) &&
               !f_pillar(rx[10:0] - 11'd1, by[10:0] - 11'd1);
    endfunction

    always_comb begin
        w_overlap = 1'b0;
        for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
            if (blast_active[i] &&
                f_overlap(r_x, r_y, blast_x[10*i +: 10], blast_y[10*i +: 10],
                          blast_xs[10*i +: 10], blast_ys[10*i +: 10]))
                w_overlap = 1'b1;
        end
    end

    always_comb begin
        w_cx   = {2'b00, r_x};
        w_cy   = {2'b00, r_y};
        w_move = 1'b1;
        if (keycode == KEY_UP)
            w_cy = {2'b00, r_y} - 12'(STEP);
        else if (keycode == KEY_DOWN)
            w_cy = {2'b00, r_y} + 12'(STEP);
        else if (keycode == KEY_LEFT)
            w_cx = {2'b00, r_x} - 12'(STEP);
        else if (keycode == KEY_RIGHT)
            w_cx = {2'b00, r_x} + 12'(STEP);
        else
            w_move = 1'b0;
    end

    assign w_legal     = f_legal(w_cx, w_cy);
    assign w_hit       = (r_state == S_ALIVE) && (r_invuln == '0) && w_overlap;
    assign w_bomb_edge = (keycode == KEY_BOMB) && (r_prev_key != KEY_BOMB);

    always_comb begin
        w_state_next   = r_state;
        w_x_next       = r_x;
        w_y_next       = r_y;
        w_lives_next   = r_lives;
        w_invuln_next  = r_invuln;
        w_hitcnt_next  = r_hitcnt;
        w_bomb_next    = 1'b0;
        w_collide_next = 1'b0;
        w_cool_next    = (r_cool != '0) ? r_cool - 16'd1 : r_cool;
        case (r_state)
            S_ALIVE: begin
                if (r_invuln != '0)
                    w_invuln_next = r_invuln - 16'd1;
                // A hit suppresses both the move and any bomb drop this frame.
                if (w_hit) begin
                    w_collide_next = 1'b1;
                    w_lives_next   = (r_lives != 4'd0) ? r_lives - 4'd1 : 4'd0;
                    w_hitcnt_next  = '0;
                    w_state_next   = S_HIT;
                end else begin
                    if (w_move && w_legal) begin
                        w_x_next = w_cx[9:0];
                        w_y_next = w_cy[9:0];
                    end
                    if (w_bomb_edge && (r_cool == '0)) begin
                        w_bomb_next = 1'b1;
                        w_cool_next = 16'(BOMB_COOLDOWN);
                    end
                end
            end
            S_HIT: begin
                if (r_hitcnt == 16'(DEATH_FRAMES - 1))
                    w_state_next = (r_lives == 4'd0) ? S_DEAD : S_RESPAWN;
                else
                    w_hitcnt_next = r_hitcnt + 16'd1;
            end
            S_RESPAWN: begin
                w_x_next      = 10'(SPAWN_X);
                w_y_next      = 10'(SPAWN_Y);
                w_invuln_next = 16'(INVULN_FRAMES);
                w_state_next  = S_ALIVE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_ALIVE;
            r_x        <= 10'(SPAWN_X);
            r_y        <= 10'(SPAWN_Y);
            r_lives    <= 4'(LIVES);
            r_invuln   <= '0;
            r_cool     <= '0;
            r_hitcnt   <= '0;
            r_prev_key <= '0;
            r_bomb     <= 1'b0;
            r_collide  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_lives    <= w_lives_next;
            r_invuln   <= w_invuln_next;
            r_cool     <= w_cool_next;
            r_hitcnt   <= w_hitcnt_next;
            r_prev_key <= keycode;
            r_bomb     <= w_bomb_next;
            r_collide  <= w_collide_next;
        end
    end

    assign userX     = r_x;
    assign userY     = r_y;
    assign bomb_drop = r_bomb;
    assign collide   = r_collide;
    assign lives     = r_lives;
    assign state     = r_state;
    assign invuln    = (r_invuln != '0);

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: stimulus queues expected pulses,
// a negedge monitor matches every bomb_drop/collide pulse against the queue.
module tb_player_ctrl;

    localparam logic [7:0] K_UP    = 8'h52;
    localparam logic [7:0] K_DOWN  = 8'h51;
    localparam logic [7:0] K_LEFT  = 8'h50;
    localparam logic [7:0] K_RIGHT = 8'h4F;
    localparam logic [7:0] K_BOMB  = 8'h13;
    localparam logic [1:0] EV_BOMB = 2'b01;
    localparam logic [1:0] EV_COLL = 2'b10;
    localparam int unsigned ST_ALIVE = 0, ST_HIT = 1, ST_RESPAWN = 2, ST_DEAD = 3;

    logic        frame_clk = 1'b0;
    logic        Reset     = 1'b0;
    logic [7:0]  keycode   = 8'h00;
    logic [39:0] bx = '0, by = '0, bxs = '0, bys = '0;
    logic [3:0]  bact = '0;
    logic [9:0]  userX, userY;
    logic        bomb_drop, collide, invuln;
    logic [3:0]  lives;
    logic [1:0]  state;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned hc;
    int unsigned d0;

    typedef struct {
        logic [1:0]  kind;
        int unsigned at;
        logic [3:0]  lv;
        logic [1:0]  st;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    player_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .blast_x     (bx),
        .blast_y     (by),
        .blast_xs    (bxs),
        .blast_ys    (bys),
        .blast_active(bact),
        .userX       (userX),
        .userY       (userY),
        .bomb_drop   (bomb_drop),
        .collide     (collide),
        .lives       (lives),
        .state       (state),
        .invuln      (invuln)
    );

    always #5 frame_clk = ~frame_clk;
    always @(posedge frame_clk) cyc <= cyc + 1;

    always @(negedge frame_clk) begin
        if (collide || bomb_drop) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: collide=%0d bomb_drop=%0d at cycle %0d, required no pulse",
                         collide, bomb_drop, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind != {collide, bomb_drop} || mon_e.at != cyc ||
                    mon_e.lv != lives || mon_e.st != state) begin
                    n_fail++;
                    $display("FAIL pulse_match: got kind=%b cyc=%0d lives=%0d state=%0d, required kind=%b cyc=%0d lives=%0d state=%0d",
                             {collide, bomb_drop}, cyc, lives, state,
                             mon_e.kind, mon_e.at, mon_e.lv, mon_e.st);
                end
            end
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input int unsigned at,
                             input logic [3:0] lv, input int unsigned st);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.lv   = lv;
        e.st   = 2'(st);
        exp_q.push_back(e);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic run_to(input int unsigned target);
        if (target > cyc) tick(target - cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1 Reset = 1'b1;
        #1;
        check("rst_x", userX, 32);
        check("rst_y", userY, 32);
        check("rst_lives", lives, 3);
        check("rst_state", state, ST_ALIVE);
        check("rst_pulses", {30'd0, collide, bomb_drop}, 0);
        check("rst_invuln", invuln, 0);
        tick(2);
        Reset = 1'b0;

        // Arena bound on the left, then free movement right.
        keycode = K_LEFT;  tick(5);
        check("left_bound_x", userX, 32);
        keycode = K_RIGHT; tick(14);
        check("right14_x", userX, 46);
        check("right14_y", userY, 32);
        keycode = K_DOWN;  tick(6);
        check("down6_y", userY, 38);
        tick(3);
        check("pillar_block_y", userY, 38);
        keycode = K_UP;    tick(1);
        check("up_after_block_y", userY, 37);
        keycode = 8'h00;   tick(2);

        // Bomb edge detect and cooldown boundary.
        keycode = K_BOMB;
        d0 = cyc + 1;
        expect_ev(EV_BOMB, d0, 3, ST_ALIVE);
        tick(10);
        keycode = 8'h00;
        run_to(d0 + 29);
        keycode = K_BOMB;  tick(2);
        keycode = 8'h00;
        run_to(d0 + 59);
        keycode = K_BOMB;  tick(1);
        keycode = 8'h00;   tick(1);
        keycode = K_BOMB;
        expect_ev(EV_BOMB, cyc + 1, 3, ST_ALIVE);
        tick(2);
        keycode = 8'h00;
        tick(62);

        // Blast in slot 2 together with a bomb press: hit wins.
        bx[29:20] = 10'd32; by[29:20] = 10'd32; bxs[29:20] = 10'd64; bys[29:20] = 10'd64;
        bact = 4'b0100;
        keycode = K_BOMB;
        hc = cyc + 1;
        expect_ev(EV_COLL, hc, 2, ST_HIT);
        tick(1);
        for (int unsigned h = 1; h <= 3; h++) begin
            keycode = K_RIGHT;
            check("hit_state", state, ST_HIT);
            check("hit_lives", lives, 3 - h);
            check("hit_hold_x", userX, (h == 1) ? 46 : 32);
            run_to(hc + 29);
            check("hit_last_frame_state", state, ST_HIT);
            run_to(hc + 30);
            if (h < 3) begin
                check("respawn_state", state, ST_RESPAWN);
                keycode = 8'h00;
                run_to(hc + 31);
                check("alive_state", state, ST_ALIVE);
                check("spawn_x", userX, 32);
                check("spawn_y", userY, 32);
                check("invuln_start", invuln, 1);
                run_to(hc + 150);
                check("invuln_last", invuln, 1);
                run_to(hc + 151);
                check("invuln_end", invuln, 0);
                check("invuln_end_state", state, ST_ALIVE);
                hc = hc + 152;
                expect_ev(EV_COLL, hc, 4'(3 - (h + 1)), ST_HIT);
                run_to(hc);
            end
        end
        check("dead_state", state, ST_DEAD);
        check("dead_lives", lives, 0);
        tick(5);
        keycode = K_BOMB;  tick(5);
        keycode = K_LEFT;  tick(5);
        keycode = 8'h00;   tick(2);
        check("dead_hold_state", state, ST_DEAD);
        check("dead_hold_x", userX, 32);
        check("dead_hold_y", userY, 32);
        check("dead_hold_lives", lives, 0);

        // Reset mid-HIT.
        Reset = 1'b1;
        bact  = 4'b0000;
        tick(1);
        Reset = 1'b0;
        bact  = 4'b0100;
        hc = cyc + 1;
        expect_ev(EV_COLL, hc, 2, ST_HIT);
        run_to(hc + 9);
        check("pre_reset_hit_state", state, ST_HIT);
        bact = 4'b0000;
        #2 Reset = 1'b1;
        #1;
        check("midhit_rst_state", state, ST_ALIVE);
        check("midhit_rst_lives", lives, 3);
        check("midhit_rst_x", userX, 32);
        check("midhit_rst_y", userY, 32);
        check("midhit_rst_collide", collide, 0);
        tick(2);
        Reset = 1'b0;
        tick(40);
        check("post_rst_state", state, ST_ALIVE);

        // Reset mid-cooldown clears it: an immediate new press drops.
        keycode = K_BOMB;
        expect_ev(EV_BOMB, cyc + 1, 3, ST_ALIVE);
        tick(3);
        keycode = 8'h00;   tick(5);
        Reset = 1'b1;      tick(1);
        Reset = 1'b0;
        keycode = K_BOMB;
        expect_ev(EV_BOMB, cyc + 1, 3, ST_ALIVE);
        tick(2);
        keycode = 8'h00;   tick(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
